// File: rtl/lsu_out.sv
// Response side of the LSU: tracks one outstanding access and merges split beats.
// Produces one registered completion with aligned and extended load data.
module lsu_out (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [1:0]  lsu_offset_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic        busy_o,
    output logic        stray_o
);

    typedef enum logic [1:0] {StIdle, StWaitFirst, StWaitSecond} state_e;

    state_e      state_q, state_d;
    logic        we_q, sign_q, split_q, err_acc_q;
    logic [1:0]  type_q, off_q;
    logic [31:0] beat1_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, err_q, stray_q;

    logic        capture, complete, beat1_en;
    logic        split_new, err_all;
    logic [63:0] src;
    logic [31:0] aligned, load_val, rdata_d;

    // Word at a nonzero offset, or halfword at offset 3, crosses a word boundary.
    assign split_new = ((lsu_type_i == 2'b00 || lsu_type_i == 2'b11) && lsu_offset_i != 2'b00) ||
                       (lsu_type_i == 2'b01 && lsu_offset_i == 2'b11);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = 1'b0;
        beat1_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = StWaitFirst;
                end
            end
            StWaitFirst: begin
                if (data_rvalid_i) begin
                    if (split_q) begin
                        beat1_en = 1'b1;
                        state_d  = StWaitSecond;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            StWaitSecond: begin
                if (data_rvalid_i) complete = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // A request arriving with the completing beat is taken back-to-back.
        if (complete) begin
            capture = req_i;
            state_d = req_i ? StWaitFirst : StIdle;
        end
    end

    // Treat {beat2, beat1} as one 64-bit window and shift the access down to bit 0.
    assign src     = split_q ? {data_rdata_i, beat1_q} : {32'b0, data_rdata_i};
    assign aligned = 32'(src >> {off_q, 3'b000});

    always_comb begin
        load_val = aligned;
        case (type_q)
            2'b01:   load_val = {{16{sign_q & aligned[15]}}, aligned[15:0]};
            2'b10:   load_val = {{24{sign_q & aligned[7]}}, aligned[7:0]};
            default: load_val = aligned;
        endcase
    end

    assign err_all = err_acc_q | data_err_i;
    assign rdata_d = (we_q || err_all) ? 32'b0 : load_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            split_q   <= 1'b0;
            type_q    <= 2'b00;
            off_q     <= 2'b00;
            err_acc_q <= 1'b0;
            beat1_q   <= 32'b0;
            rdata_q   <= 32'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= complete;
            if (capture) begin
                we_q      <= lsu_we_i;
                sign_q    <= lsu_sign_ext_i;
                split_q   <= split_new;
                type_q    <= lsu_type_i;
                off_q     <= lsu_offset_i;
                err_acc_q <= 1'b0;
            end
            if (beat1_en) begin
                beat1_q   <= data_rdata_i;
                err_acc_q <= err_acc_q | data_err_i;
            end
            if (complete) begin
                rdata_q <= rdata_d;
                err_q   <= err_all;
            end
            if (state_q == StIdle && data_rvalid_i) stray_q <= 1'b1;
        end
    end

    assign lsu_rdata_o  = rdata_q;
    assign lsu_rvalid_o = rvalid_q;
    assign lsu_err_o    = err_q;
    assign busy_o       = (state_q != StIdle);
    assign stray_o      = stray_q;

endmodule

// File: tb/tb_lsu_out.sv
// Directed bench for lsu_out: aligned, extended, split, error, back-to-back, stray and reset cases.
module tb_lsu_out;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req, we, sign, rvalid, err;
    logic [1:0]  typ, off;
    logic [31:0] rdata;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid, lsu_err, busy, stray;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_out dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req),
        .lsu_we_i       (we),
        .lsu_type_i     (typ),
        .lsu_sign_ext_i (sign),
        .lsu_offset_i   (off),
        .data_rvalid_i  (rvalid),
        .data_rdata_i   (rdata),
        .data_err_i     (err),
        .lsu_rdata_o    (lsu_rdata),
        .lsu_rvalid_o   (lsu_rvalid),
        .lsu_err_o      (lsu_err),
        .busy_o         (busy),
        .stray_o        (stray)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] t, input logic s, input logic [1:0] o);
        req = 1'b1; we = w; typ = t; sign = s; off = o;
        tick();
        req = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic e);
        rvalid = 1'b1; rdata = d; err = e;
        tick();
        rvalid = 1'b0; rdata = 32'h0; err = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; req = 1'b0; we = 1'b0; typ = 2'b00; sign = 1'b0; off = 2'b00;
        rvalid = 1'b0; rdata = 32'h0; err = 1'b0;
        #12;
        chk("reset_rdata", lsu_rdata, 32'h0);
        chk("reset_rvalid", {31'b0, lsu_rvalid}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_stray", {31'b0, stray}, 32'h0);
        rst_ni = 1'b1;
        tick();

        // Aligned word load
        issue(1'b0, 2'b00, 1'b0, 2'd0);
        chk("word_busy_after_req", {31'b0, busy}, 32'h1);
        chk("word_no_early_rvalid", {31'b0, lsu_rvalid}, 32'h0);
        beat(32'hDEADBEEF, 1'b0);
        chk("word_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("word_rdata", lsu_rdata, 32'hDEADBEEF);
        chk("word_err", {31'b0, lsu_err}, 32'h0);
        chk("word_busy_done", {31'b0, busy}, 32'h0);
        tick();
        chk("word_rvalid_one_cycle", {31'b0, lsu_rvalid}, 32'h0);
        chk("word_rdata_hold", lsu_rdata, 32'hDEADBEEF);

        // Byte loads at offset 2, signed then unsigned
        issue(1'b0, 2'b10, 1'b1, 2'd2);
        beat(32'h0080_0000, 1'b0);
        chk("byte_signed", lsu_rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'b10, 1'b0, 2'd2);
        beat(32'h0080_0000, 1'b0);
        chk("byte_unsigned", lsu_rdata, 32'h0000_0080);

        // Halfword at offset 1, signed
        issue(1'b0, 2'b01, 1'b1, 2'd1);
        beat(32'h12_9ABC_34, 1'b0);
        chk("half_off1_signed", lsu_rdata, 32'hFFFF_9ABC);

        // Split word at offset 1
        issue(1'b0, 2'b00, 1'b0, 2'd1);
        beat(32'h44332211, 1'b0);
        chk("split_no_rvalid_beat1", {31'b0, lsu_rvalid}, 32'h0);
        chk("split_busy_beat1", {31'b0, busy}, 32'h1);
        beat(32'h88776655, 1'b0);
        chk("split_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("split_word_off1", lsu_rdata, 32'h55443322);

        // Split word at offset 3
        issue(1'b0, 2'b00, 1'b0, 2'd3);
        beat(32'h44332211, 1'b0);
        beat(32'h88776655, 1'b0);
        chk("split_word_off3", lsu_rdata, 32'h77665544);

        // Split halfword with error on beat 1
        issue(1'b0, 2'b01, 1'b1, 2'd3);
        beat(32'hAB00_0000, 1'b1);
        chk("split_err_wait", {31'b0, lsu_rvalid}, 32'h0);
        beat(32'h0000_00CD, 1'b0);
        chk("split_err_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("split_err_flag", {31'b0, lsu_err}, 32'h1);
        chk("split_err_rdata", lsu_rdata, 32'h0);

        // Store completes in the same cycle a byte load is issued
        issue(1'b1, 2'b00, 1'b0, 2'd0);
        rvalid = 1'b1; rdata = 32'hCAFEF00D; err = 1'b0;
        req = 1'b1; we = 1'b0; typ = 2'b10; sign = 1'b0; off = 2'd0;
        tick();
        req = 1'b0; rvalid = 1'b0;
        chk("store_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("store_rdata", lsu_rdata, 32'h0);
        chk("store_err", {31'b0, lsu_err}, 32'h0);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        beat(32'h0000_007F, 1'b0);
        chk("b2b_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("b2b_rdata", lsu_rdata, 32'h0000_007F);
        chk("b2b_idle", {31'b0, busy}, 32'h0);
        tick();

        // Stray response in idle
        chk("stray_before", {31'b0, stray}, 32'h0);
        beat(32'h1234_5678, 1'b0);
        chk("stray_set", {31'b0, stray}, 32'h1);
        chk("stray_no_rvalid", {31'b0, lsu_rvalid}, 32'h0);
        chk("stray_rdata_hold", lsu_rdata, 32'h0000_007F);

        // Reset while waiting for the second beat
        issue(1'b0, 2'b00, 1'b0, 2'd2);
        beat(32'h1111_1111, 1'b0);
        chk("pre_reset_busy", {31'b0, busy}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stray", {31'b0, stray}, 32'h0);
        chk("rst_err", {31'b0, lsu_err}, 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        beat(32'h2222_2222, 1'b0);
        chk("post_rst_no_completion", {31'b0, lsu_rvalid}, 32'h0);
        chk("post_rst_stray", {31'b0, stray}, 32'h1);
        tick();
        chk("post_rst_still_no_rvalid", {31'b0, lsu_rvalid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
